// File: rtl/freq_sweep_pkg.sv
// freq_sweep_pkg
// Shared definitions for the frequency-sweep handshake: the stepper FSM
// state encoding and the default sweep constants. DEF_LOCK_SETTLE is also
// the lock-settle threshold used by ram_top, so both ends agree on what
// "stably locked" means.
// No ports (package).
package freq_sweep_pkg;

    localparam int DEF_FW           = 9;
    localparam int DEF_F_MIN        = 50;
    localparam int DEF_F_MAX        = 400;
    localparam int DEF_LOCK_SETTLE  = 32;
    localparam int DEF_BUSY_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        PROG      = 2'd0,
        WAIT_BUSY = 2'd1,
        SETTLE    = 2'd2,
        READY     = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/lock_settle_counter.sv
// lock_settle_counter
// Saturating count of consecutive cycles with `inc` high. `done` is high
// while the count sits at LIMIT-1, i.e. LIMIT qualifying cycles have been
// seen once the current one (with inc high) is included.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous clear (wins over inc)
//   inc      : count this cycle
//   done     : count has reached LIMIT-1
module lock_settle_counter
    import freq_sweep_pkg::*;
#(
    parameter int LIMIT = DEF_LOCK_SETTLE
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic done
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] TOP = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != TOP)) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == TOP);

endmodule

// File: rtl/pll_freq_stepper.sv
// pll_freq_stepper
// Responder end of the frequency-sweep handshake. Steps a frequency code
// on request, programs the PLL reconfiguration core and reports when the
// PLL is stably locked at the new code.
//
// Handshakes:
//   next_frequency/freq_ready : a one-cycle request is taken in a READY cycle
//     (freq_ready high); requests outside READY are held in a one-deep
//     pending flag and served on the first READY cycle.
//   cfg_write/cfg_busy : cfg_write pulses for one cycle with cfg_mult valid;
//     busy is ignored in that write cycle, and the core is considered done
//     on the first later cycle busy is low (or after BUSY_TIMEOUT cycles).
//
// Ports:
//   CLOCK_50, reset  : clock, asynchronous active-high reset
//   next_frequency   : one-cycle step request
//   add[3:0]         : step size, sampled when the step is taken
//   frequency        : current frequency code (== cfg_mult)
//   freq_ready       : PLL programmed and stably locked at frequency
//   cfg_write        : one-cycle reconfiguration start pulse
//   cfg_mult         : code presented to the reconfiguration core
//   cfg_busy         : reconfiguration core busy
//   pll_locked       : synchronised PLL lock indicator
//   cfg_error        : sticky busy-timeout flag
//   sweep_wrapped    : (PLL_FREQ_STEPPER_WRAP_FLAG_EN only) pulses on a step
//                      that wraps to F_MIN; further steps are then inhibited
module pll_freq_stepper
    import freq_sweep_pkg::*;
#(
    parameter int FW           = DEF_FW,
    parameter int F_MIN        = DEF_F_MIN,
    parameter int F_MAX        = DEF_F_MAX,
    parameter int LOCK_SETTLE  = DEF_LOCK_SETTLE,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          next_frequency,
    input  logic [3:0]    add,
    output logic [FW-1:0] frequency,
    output logic          freq_ready,
    output logic          cfg_write,
    output logic [FW-1:0] cfg_mult,
    input  logic          cfg_busy,
    input  logic          pll_locked,
    output logic          cfg_error
`ifdef PLL_FREQ_STEPPER_WRAP_FLAG_EN
    ,
    output logic          sweep_wrapped
`endif
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST    = TW'(BUSY_TIMEOUT - 1);
    localparam logic [FW:0]   F_MAX_EXT = (FW+1)'(F_MAX);
    localparam logic [FW-1:0] F_MIN_C   = FW'(F_MIN);

    sweep_state_t  state, state_n;
    logic [FW-1:0] freq_n;
    logic          pending, pending_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          ready_n, write_n, error_n;
    logic          settle_done, settle_clear, settle_inc;
    logic [FW:0]   sum;
    logic          wraps;
`ifdef PLL_FREQ_STEPPER_WRAP_FLAG_EN
    logic          wrapped_seen, seen_n, wrap_pulse_n;
`endif

    // Sum in FW+1 bits so an overflow past 2^FW still compares above F_MAX.
    assign sum   = {1'b0, frequency} + {{(FW-3){1'b0}}, add};
    assign wraps = (sum > F_MAX_EXT);

    // Counter runs only while locked in SETTLE; anything else restarts it,
    // which also gives the clear on every SETTLE entry.
    assign settle_inc   = (state == SETTLE) && pll_locked;
    assign settle_clear = !settle_inc;

    lock_settle_counter #(
        .LIMIT (LOCK_SETTLE)
    ) u_settle (
        .clk   (CLOCK_50),
        .rst   (reset),
        .clear (settle_clear),
        .inc   (settle_inc),
        .done  (settle_done)
    );

    always_comb begin
        state_n   = state;
        freq_n    = frequency;
        pending_n = pending | next_frequency;
        tcnt_n    = tcnt;
        error_n   = cfg_error;
`ifdef PLL_FREQ_STEPPER_WRAP_FLAG_EN
        seen_n       = wrapped_seen;
        wrap_pulse_n = 1'b0;
`endif
        case (state)
            PROG: begin
                tcnt_n  = '0;
                state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                tcnt_n = tcnt + 1'b1;
                // tcnt == 0 is the write cycle; busy cannot be valid yet.
                if ((tcnt != '0) && !cfg_busy) begin
                    state_n = SETTLE;
                end else if (tcnt == T_LAST) begin
                    state_n = SETTLE;
                    error_n = 1'b1;
                end
            end
            SETTLE: begin
                if (pll_locked && settle_done) begin
                    state_n = READY;
                end
            end
            READY: begin
                // Lock loss wins; a simultaneous request stays pending.
                if (!pll_locked) begin
                    state_n = SETTLE;
                end else if (pending || next_frequency) begin
                    pending_n = 1'b0;
`ifdef PLL_FREQ_STEPPER_WRAP_FLAG_EN
                    if (!wrapped_seen) begin
                        freq_n       = wraps ? F_MIN_C : sum[FW-1:0];
                        state_n      = PROG;
                        wrap_pulse_n = wraps;
                        seen_n       = wraps;
                    end
`else
                    freq_n  = wraps ? F_MIN_C : sum[FW-1:0];
                    state_n = PROG;
`endif
                end
            end
            default: state_n = PROG;
        endcase
        write_n = (state == PROG);
        ready_n = (state_n == READY);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= PROG;
            frequency  <= F_MIN_C;
            freq_ready <= 1'b0;
            cfg_write  <= 1'b0;
            cfg_error  <= 1'b0;
            pending    <= 1'b0;
            tcnt       <= '0;
`ifdef PLL_FREQ_STEPPER_WRAP_FLAG_EN
            wrapped_seen  <= 1'b0;
            sweep_wrapped <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            frequency  <= freq_n;
            freq_ready <= ready_n;
            cfg_write  <= write_n;
            cfg_error  <= error_n;
            pending    <= pending_n;
            tcnt       <= tcnt_n;
`ifdef PLL_FREQ_STEPPER_WRAP_FLAG_EN
            wrapped_seen  <= seen_n;
            sweep_wrapped <= wrap_pulse_n;
`endif
        end
    end

    assign cfg_mult = frequency;

endmodule

// File: tb/tb_pll_freq_stepper.sv
// tb_pll_freq_stepper
// Self-checking bench for pll_freq_stepper. Emulates the reconfiguration
// core (busy for a chosen number of cycles after each write) and keeps a
// transaction-level model of the sweep: expected code after each step and
// expected write-to-ready latency. Build with PLL_FREQ_STEPPER_WRAP_FLAG_EN
// defined to exercise the wrap flag.
module tb_pll_freq_stepper;
    import freq_sweep_pkg::*;

    localparam int FW           = 9;
    localparam int F_MIN        = 50;
    localparam int F_MAX        = 400;
    localparam int LOCK_SETTLE  = 32;
    localparam int BUSY_TIMEOUT = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic          next_frequency;
    logic [3:0]    add;
    logic [FW-1:0] frequency;
    logic          freq_ready;
    logic          cfg_write;
    logic [FW-1:0] cfg_mult;
    logic          cfg_busy;
    logic          pll_locked;
    logic          cfg_error;
`ifdef PLL_FREQ_STEPPER_WRAP_FLAG_EN
    logic          sweep_wrapped;
`endif

    pll_freq_stepper #(
        .FW           (FW),
        .F_MIN        (F_MIN),
        .F_MAX        (F_MAX),
        .LOCK_SETTLE  (LOCK_SETTLE),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .CLOCK_50       (clk),
        .reset          (reset),
        .next_frequency (next_frequency),
        .add            (add),
        .frequency      (frequency),
        .freq_ready     (freq_ready),
        .cfg_write      (cfg_write),
        .cfg_mult       (cfg_mult),
        .cfg_busy       (cfg_busy),
        .pll_locked     (pll_locked),
        .cfg_error      (cfg_error)
`ifdef PLL_FREQ_STEPPER_WRAP_FLAG_EN
        ,
        .sweep_wrapped  (sweep_wrapped)
`endif
    );

    // ---------------- clock ----------------
    always #10 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int write_count = 0;
    int last_write_cyc = 0;
    int err_rise_cyc = -1;
    int busy_len = 0;
    int busy_left = 0;
    bit busy_hold = 1'b0;
    int model_freq = F_MIN;
`ifdef PLL_FREQ_STEPPER_WRAP_FLAG_EN
    bit model_seen = 1'b0;
`endif
    logic [FW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Next code per the sweep rule.
    function automatic int model_next(input int f, input int a);
        if (f + a > F_MAX) return F_MIN;
        return f + a;
    endfunction

    // Cycles from the write cycle to the first freq_ready cycle. Busy is not
    // looked at in the write cycle; the block leaves the busy wait at the end
    // of the first later cycle with busy low (or after BUSY_TIMEOUT cycles),
    // then needs LOCK_SETTLE locked cycles.
    function automatic int exp_ready_lat(input int b, input bit hold);
        int settle_entry;
        if (hold) settle_entry = BUSY_TIMEOUT;
        else settle_entry = ((b < 1) ? 1 : b) + 1;
        return settle_entry + LOCK_SETTLE;
    endfunction

    // One clock: sample at the falling edge, log writes, emulate the core.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (cfg_error && (err_rise_cyc < 0)) err_rise_cyc = cyc;
        if (cfg_write) begin
            write_count++;
            last_write_cyc = cyc;
            if (exp_q.size() == 0) check("unexpected_write", 1, 0);
            else check("cfg_mult", cfg_mult, exp_q.pop_front());
            busy_left = busy_len;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        cfg_busy = busy_hold || (busy_left > 0);
    endtask

    task automatic wait_ready(output int lat);
        int n;
        n = 0;
        while (!freq_ready && (n < 3000)) begin
            tick();
            n++;
        end
        lat = n;
        if (!freq_ready) check("ready_timeout", 0, 1);
    endtask

    // Called at a READY sample point with the request (pulse or pending)
    // and add already applied; the step is taken at the next clock.
    task automatic take_step(input int b);
        int nf, lat, w0;
        bit wrap, ignore;
        w0 = write_count;
        busy_len = b;
        nf = model_next(model_freq, int'(add));
        wrap = (model_freq + int'(add) > F_MAX);
`ifdef PLL_FREQ_STEPPER_WRAP_FLAG_EN
        ignore = model_seen;
`else
        ignore = 1'b0;
`endif
        if (ignore) begin
            tick();
            next_frequency = 1'b0;
            check("ignored_ready", freq_ready, 1);
            check("ignored_freq", frequency, model_freq);
            repeat (4) tick();
            check("ignored_no_write", write_count - w0, 0);
        end else begin
            exp_q.push_back(FW'(nf));
            tick();
            next_frequency = 1'b0;
            check("step_ready_low", freq_ready, 0);
            check("step_freq", frequency, nf);
`ifdef PLL_FREQ_STEPPER_WRAP_FLAG_EN
            check("wrap_pulse", sweep_wrapped, wrap);
            if (wrap) model_seen = 1'b1;
`endif
            model_freq = nf;
            tick();
            check("step_one_write", write_count - w0, 1);
`ifdef PLL_FREQ_STEPPER_WRAP_FLAG_EN
            check("wrap_pulse_len", sweep_wrapped, 0);
`endif
            wait_ready(lat);
            check("ready_latency", cyc - last_write_cyc, exp_ready_lat(b, busy_hold));
            check("step_write_total", write_count - w0, 1);
            check("ready_freq", frequency, model_freq);
        end
    endtask

    task automatic do_step(input int a, input int b);
        add = 4'(a);
        next_frequency = 1'b1;
        take_step(b);
    endtask

    // Lock loss in READY. mode 0: plain; 1: request in the same cycle;
    // 2: request during SETTLE (needs low >= 2).
    task automatic lock_drop(input int low, input int mode, input int a, input int b);
        int w0, lat;
        w0 = write_count;
        pll_locked = 1'b0;
        if (mode == 1) begin
            add = 4'(a);
            next_frequency = 1'b1;
        end
        tick();
        next_frequency = 1'b0;
        check("drop_ready_low", freq_ready, 0);
        for (int i = 1; i < low; i++) begin
            if ((mode == 2) && (i == 1)) begin
                add = 4'(a);
                next_frequency = 1'b1;
            end
            tick();
            next_frequency = 1'b0;
        end
        pll_locked = 1'b1;
        wait_ready(lat);
        check("relock_latency", lat, LOCK_SETTLE);
        check("drop_freq", frequency, model_freq);
        check("drop_no_write", write_count - w0, 0);
        if (mode != 0) take_step(b);
    endtask

    task automatic release_reset(input int b);
        int lat;
        model_freq = F_MIN;
`ifdef PLL_FREQ_STEPPER_WRAP_FLAG_EN
        model_seen = 1'b0;
`endif
        exp_q.delete();
        exp_q.push_back(FW'(F_MIN));
        busy_len = b;
        write_count = 0;
        reset = 1'b0;
        wait_ready(lat);
        check("init_write_count", write_count, 1);
        check("init_latency", cyc - last_write_cyc, exp_ready_lat(b, 1'b0));
        check("init_freq", frequency, F_MIN);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat, dwell, act, w0;
        reset = 1'b1;
        next_frequency = 1'b0;
        add = 4'd0;
        cfg_busy = 1'b0;
        pll_locked = 1'b1;

        repeat (3) tick();
        check("rst_freq", frequency, F_MIN);
        check("rst_ready", freq_ready, 0);
        check("rst_write", cfg_write, 0);
        check("rst_error", cfg_error, 0);
        check("rst_no_write", write_count, 0);

        // Power-up: programs F_MIN once, no busy from the core.
        release_reset(0);

        // Directed steps: +1, then add=0 reprograms the same code.
        do_step(1, 3);
        check("step51", frequency, 51);
        do_step(0, 2);

        // Lock loss variants in READY.
        lock_drop(5, 0, 0, 0);
        lock_drop(3, 1, 4, 1);
        lock_drop(4, 2, 9, 5);

        // Busy stuck: timeout sets sticky cfg_error.
        check("err_before_timeout", cfg_error, 0);
        busy_hold = 1'b1;
        do_step(2, 0);
        check("err_rise_offset", err_rise_cyc - last_write_cyc, BUSY_TIMEOUT);
        busy_hold = 1'b0;
        do_step(3, 4);
        check("err_sticky", cfg_error, 1);

        // Randomised sweep.
        for (int it = 0; it < 30; it++) begin
            dwell = $urandom_range(0, 3);
            repeat (dwell) tick();
            check("dwell_ready", freq_ready, 1);
            act = $urandom_range(0, 9);
            if (act < 7) do_step($urandom_range(0, 15), $urandom_range(0, 12));
            else if (act == 7) lock_drop($urandom_range(1, 6), 0, 0, 0);
            else if (act == 8) lock_drop($urandom_range(1, 6), 1, $urandom_range(0, 15), $urandom_range(0, 12));
            else lock_drop($urandom_range(2, 6), 2, $urandom_range(0, 15), $urandom_range(0, 12));
        end

        // Reset in the middle of a reconfiguration.
        add = 4'd5;
        next_frequency = 1'b1;
        busy_len = 6;
        exp_q.push_back(FW'(model_next(model_freq, 5)));
        tick();
        next_frequency = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        busy_left = 0;
        tick();
        w0 = write_count;
        check("midrst_freq", frequency, F_MIN);
        check("midrst_ready", freq_ready, 0);
        check("midrst_write", cfg_write, 0);
        check("midrst_error", cfg_error, 0);
        repeat (3) tick();
        check("midrst_no_write", write_count - w0, 0);
        err_rise_cyc = -1;
        release_reset($urandom_range(0, 8));

        // Climb to 398, then +3 wraps to F_MIN.
        while (model_freq + 15 < 398) do_step(15, $urandom_range(0, 4));
        do_step(398 - model_freq, 1);
        check("at398", frequency, 398);
        do_step(3, 2);
        check("wrapped_to_min", frequency, F_MIN);
        do_step(7, 1);
`ifdef PLL_FREQ_STEPPER_WRAP_FLAG_EN
        check("inhibited_after_wrap", frequency, F_MIN);
`else
        check("continues_after_wrap", frequency, F_MIN + 7);
`endif
        check("no_stray_expect", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pll_freq_stepper.md
Name: pll_freq_stepper

Overview:
- Responder end of the frequency-sweep handshake used by the RAM test controllers.
- Accepts single-cycle `next_frequency` requests and steps a 9-bit frequency code by `add`.
- Drives a write/busy handshake to the PLL reconfiguration core, then waits for stable PLL lock before raising `freq_ready`.
- Sits between the PLL reconfiguration core and every `ram_top` instance; all instances share its `frequency` and `freq_ready` outputs.

Parameters:
- FW, 9, width of the frequency code.
- F_MIN, 50, first code of the sweep; the wrap-around target.
- F_MAX, 400, last legal code. Must satisfy F_MIN <= F_MAX < 2^FW.
- LOCK_SETTLE, 32, consecutive locked cycles required before `freq_ready` asserts.
- BUSY_TIMEOUT, 1024, maximum cycles spent waiting for `cfg_busy` to fall.

Ports:
- CLOCK_50 in 1: sole clock.
- reset in 1: asynchronous, active-high reset.
- next_frequency in 1: one-cycle request to advance the frequency.
- add in 4: step size, sampled in the cycle the step is taken.
- frequency out FW: current frequency code.
- freq_ready out 1: PLL is programmed and stably locked at `frequency`.
- cfg_write out 1: one-cycle pulse that starts a reconfiguration.
- cfg_mult out FW: code presented to the reconfiguration core. Equals `frequency`.
- cfg_busy in 1: reconfiguration core is busy.
- pll_locked in 1: PLL lock indicator, already synchronised to CLOCK_50.
- cfg_error out 1: sticky flag, set when a busy timeout occurs.

Behaviour:
- Reset (asynchronous) values:
  - frequency = F_MIN
  - freq_ready = 0
  - cfg_write = 0
  - cfg_error = 0
  - pending = 0
  - counters = 0
  - state = PROG
- After reset deasserts, the block always programs F_MIN first.
- All outputs are registered.
- PROG:
  - Assert `cfg_write` for exactly one cycle.
  - Clear the timeout counter.
  - Next state: WAIT_BUSY.
- WAIT_BUSY:
  - Ignore `cfg_busy` in the first cycle after `cfg_write`.
  - Leave when `cfg_busy` == 0, or when the timeout counter reaches BUSY_TIMEOUT-1.
  - On timeout, set `cfg_error`; it is cleared only by reset.
  - In both cases go to SETTLE and clear the settle counter.
- SETTLE:
  - If `pll_locked`, increment the settle counter; otherwise clear it.
  - When the counter reaches LOCK_SETTLE-1 with `pll_locked` high, go to READY.
  - `freq_ready` rises in the cycle READY is entered.
- READY:
  - `freq_ready` = 1.
  - If `pll_locked` falls: clear `freq_ready` on the next edge, go to SETTLE, and clear the settle counter. No reprogramming occurs.
  - If `next_frequency` (or `pending`) is set:
    - Compute sum = frequency + add in FW+1 bits.
    - Set frequency = (sum > F_MAX) ? F_MIN : sum[FW-1:0].
    - Clear `freq_ready` and `pending`, then go to PROG.
  - If `add` == 0, the same code is reprogrammed.
- Requests outside READY:
  - A `next_frequency` pulse arriving outside READY sets `pending`. The queue is one deep; further pulses are merged.
  - The pending request is served on the first cycle in READY. `freq_ready` is high for exactly that one cycle.
- If `next_frequency` and a lock loss occur in the same READY cycle, the lock loss has priority and `pending` is set.
- `frequency` changes only in the READY-to-PROG transition, and it is stable while `freq_ready` is 1.
- Reset mid-operation aborts immediately. No `cfg_write` is issued while reset is high.

Optional Feature:
- Macro: PLL_FREQ_STEPPER_WRAP_FLAG_EN.
- When defined: adds output port `sweep_wrapped` (1 bit).
  - It pulses for one cycle coincident with any step that wraps to F_MIN.
  - It also drives a sticky `wrapped_seen` bit, cleared only by reset, that inhibits further stepping. Requests in READY are then ignored and `pending` is cleared.
- When undefined: the port is absent and the sweep wraps indefinitely.

Decomposition:
- Shared package `freq_sweep_pkg` holds:
  - the state enum (PROG, WAIT_BUSY, SETTLE, READY)
  - FW
  - default F_MIN / F_MAX
  - the LOCK_SETTLE default, which is shared with the settle threshold in `ram_top`.
- One natural sub-module: `lock_settle_counter`, a saturating consecutive-cycle counter with `clear`, `inc` and `done` signals.

Test Plan:
- Reset release, `cfg_busy` = 0, `pll_locked` = 1 → frequency = 50, one `cfg_write` pulse, `freq_ready` rises 32 cycles after SETTLE entry.
- In READY, `add` = 1 with a `next_frequency` pulse → `freq_ready` = 0 next cycle, frequency = 51, `cfg_mult` = 51, single `cfg_write` pulse.
- frequency = 398, `add` = 3 → wraps to 50. With the macro defined, `sweep_wrapped` pulses once and a subsequent `next_frequency` is ignored (frequency stays 50).
- `cfg_busy` held at 1 → exit WAIT_BUSY after 1024 cycles, `cfg_error` = 1 and stays 1 until reset.
- `pll_locked` drops for 5 cycles during READY → `freq_ready` = 0, frequency unchanged, no `cfg_write`, `freq_ready` returns 32 locked cycles later.
- `next_frequency` pulsed during SETTLE → READY held for exactly 1 cycle, then a step to frequency+add with a single `cfg_write`.
